demux64_deser: RTL and testbench



---
 rtl/demux64_deser.sv | 118 +++++++++++
 tb/tb_demux64_deser.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux64_deser.sv
// 1:64 serial-to-parallel demultiplexer: steers a bit stream into a 64-bit word
// by sequential index or explicit select, with valid/ready on both sides.
module demux64_deser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_bit,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mode,
    input  logic [5:0]  in_sel,
    input  logic        in_last,
    output logic [63:0] out_data,
    output logic [63:0] out_mask,
    output logic [6:0]  out_count,
    output logic        out_dup,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic {FILL, PEND} state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] mask;
        logic [6:0]  count;
        logic        dup;
    } word_t;

    state_t state, state_nx;
    word_t  asm_w, asm_nx;
    word_t  out_w, out_nx;
    word_t  beat_w;
    logic [5:0] idx, idx_nx;
    logic [5:0] pos;
    logic       out_valid_nx;
    logic       accept;
    logic       complete;

    // in_ready depends on state alone, so out_ready never reaches it combinationally.
    assign in_ready = (state == FILL);
    assign accept   = in_valid && in_ready;
    assign complete = in_last || (!in_mode && idx == 6'd63);
    assign pos      = in_mode ? in_sel : (LSB_FIRST ? idx : 6'd63 - idx);

    // The assembly word as it would look after absorbing the current beat.
    always_comb begin
        beat_w           = asm_w;
        beat_w.data[pos] = in_bit;
        beat_w.mask[pos] = 1'b1;
        beat_w.dup       = asm_w.dup | asm_w.mask[pos];
        beat_w.count     = (asm_w.count == 7'd127) ? asm_w.count : asm_w.count + 7'd1;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx     = state;
        asm_nx       = asm_w;
        idx_nx       = idx;
        out_nx       = out_w;
        out_valid_nx = out_valid && !out_ready;

        case (state)
            FILL: begin
                if (accept) begin
                    if (!complete) begin
                        asm_nx = beat_w;
                        idx_nx = in_mode ? idx : idx + 6'd1;
                    end else if (!out_valid || out_ready) begin
                        out_nx       = beat_w;
                        out_valid_nx = 1'b1;
                        asm_nx       = '0;
                        idx_nx       = '0;
                    end else begin
                        // Output slot still occupied: park the finished word in asm.
                        asm_nx   = beat_w;
                        idx_nx   = '0;
                        state_nx = PEND;
                    end
                end
            end
            PEND: begin
                if (out_ready) begin
                    out_nx       = asm_w;
                    out_valid_nx = 1'b1;
                    asm_nx       = '0;
                    idx_nx       = '0;
                    state_nx     = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            asm_w     <= '0;
            idx       <= '0;
            out_w     <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nx;
            asm_w     <= asm_nx;
            idx       <= idx_nx;
            out_w     <= out_nx;
            out_valid <= out_valid_nx;
        end
    end

    assign out_data  = out_w.data;
    assign out_mask  = out_w.mask;
    assign out_count = out_w.count;
    assign out_dup   = out_w.dup;

endmodule

// File: tb/tb_demux64_deser.sv
// Randomized and directed bench for demux64_deser; an LSB-first and an MSB-first
// instance share the same input stream and are checked against a word-level model.
module tb_demux64_deser;

    typedef struct packed {
        logic [63:0] data;
        logic [63:0] mask;
        logic [6:0]  count;
        logic        dup;
    } word_t;

    typedef struct {
        logic       b;
        logic       m;
        logic [5:0] s;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_bit = 1'b0, in_valid = 1'b0, in_mode = 1'b0, in_last = 1'b0;
    logic [5:0]  in_sel = '0;
    logic        out_ready = 1'b0;
    logic        ia_ready, ib_ready;
    logic [63:0] oa_data, oa_mask, ob_data, ob_mask;
    logic [6:0]  oa_count, ob_count;
    logic        oa_dup, ob_dup, oa_valid, ob_valid;

    int    total = 0;
    int    bad = 0;
    bit    rand_ready = 1'b0;
    beat_t wq[$];
    word_t exp_a[$], exp_b[$], cap_a[$], cap_b[$];

    always #5 clk = ~clk;

    demux64_deser #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(ia_ready),
        .in_mode(in_mode), .in_sel(in_sel), .in_last(in_last), .out_data(oa_data),
        .out_mask(oa_mask), .out_count(oa_count), .out_dup(oa_dup), .out_valid(oa_valid),
        .out_ready(out_ready)
    );

    demux64_deser #(.LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_ready(ib_ready),
        .in_mode(in_mode), .in_sel(in_sel), .in_last(in_last), .out_data(ob_data),
        .out_mask(ob_mask), .out_count(ob_count), .out_dup(ob_dup), .out_valid(ob_valid),
        .out_ready(out_ready)
    );

    function automatic word_t grab_a();
        word_t w;
        w.data = oa_data; w.mask = oa_mask; w.count = oa_count; w.dup = oa_dup;
        return w;
    endfunction

    function automatic word_t grab_b();
        word_t w;
        w.data = ob_data; w.mask = ob_mask; w.count = ob_count; w.dup = ob_dup;
        return w;
    endfunction

    // Expected word from the beat list in wq: sequential beats fill positions in
    // arrival order, addressed beats go to their select, last write wins.
    function automatic word_t model_word(input bit lsb);
        word_t w = '0;
        int k = 0;
        int p;
        int n = wq.size();
        for (int i = 0; i < n; i++) begin
            if (wq[i].m) p = int'(wq[i].s);
            else begin
                p = lsb ? k : 63 - k;
                k++;
            end
            if (w.mask[p]) w.dup = 1'b1;
            w.mask[p] = 1'b1;
            w.data[p] = wq[i].b;
        end
        w.count = 7'(n > 127 ? 127 : n);
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && oa_valid && out_ready) cap_a.push_back(grab_a());
        if (rst_n && ob_valid && out_ready) cap_b.push_back(grab_b());
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic beat(input logic b, input logic m, input logic [5:0] s, input logic l);
        int  waited = 0;
        bit  ok;
        in_bit = b; in_mode = m; in_sel = s; in_last = l; in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            ok = ia_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (ok) break;
            waited++;
            if (waited > 300) begin
                bad++;
                $display("FAIL beat_timeout in_ready stuck at %0b, wanted 1", ia_ready);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_word();
        for (int i = 0; i < wq.size(); i++)
            beat(wq[i].b, wq[i].m, wq[i].s, i == wq.size() - 1);
    endtask

    task automatic rand_seq_word(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back('{b: 1'($urandom), m: 1'b0, s: 6'd0});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; out_ready = 1'b0; rand_ready = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        word_t got;
        apply_reset();
        @(negedge clk);
        got = grab_a();
        if (got !== '0 || oa_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got d=%h m=%h c=%0d u=%0b v=%0b want all 0",
                     got.data, got.mask, got.count, got.dup, oa_valid);
        end
        total++;
        if (ia_ready !== 1'b1 || ib_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %0b/%0b want 1", ia_ready, ib_ready);
        end
        total++;
        idle(1);
    endtask

    task automatic test_seq_full();
        logic [63:0] pat = 64'hA5A5_A5A5_A5A5_A5A5;
        word_t exp, got;
        out_ready = 1'b1;
        for (int i = 0; i < 63; i++) beat(pat[i], 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        if (oa_valid !== 1'b0) begin
            bad++;
            $display("FAIL seq_full_early out_valid=%0b want 0", oa_valid);
        end
        total++;
        @(posedge clk); #1;
        beat(pat[63], 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        exp = '{data: pat, mask: '1, count: 7'd64, dup: 1'b0};
        got = grab_a();
        if (oa_valid !== 1'b1 || got !== exp) begin
            bad++;
            $display("FAIL seq_full got v=%0b d=%h m=%h c=%0d u=%0b want v=1 d=%h m=%h c=64 u=0",
                     oa_valid, got.data, got.mask, got.count, got.dup, exp.data, exp.mask);
        end
        total++;
        idle(2);
    endtask

    task automatic test_short();
        logic [7:0] bits = 8'b0100_1101;
        word_t ga, gb;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) beat(bits[i], 1'b0, 6'd0, i == 7);
        @(negedge clk);
        ga = grab_a();
        gb = grab_b();
        if (ga.data !== 64'h4D || ga.mask !== 64'hFF || ga.count !== 7'd8 || oa_valid !== 1'b1) begin
            bad++;
            $display("FAIL short_lsb got d=%h m=%h c=%0d v=%0b want d=4d m=ff c=8 v=1",
                     ga.data, ga.mask, ga.count, oa_valid);
        end
        total++;
        if (gb.data !== 64'hB200_0000_0000_0000 || gb.mask !== 64'hFF00_0000_0000_0000 ||
            gb.count !== 7'd8) begin
            bad++;
            $display("FAIL short_msb got d=%h m=%h c=%0d want d=b200000000000000 m=ff00000000000000 c=8",
                     gb.data, gb.mask, gb.count);
        end
        total++;
        idle(2);
    endtask

    task automatic test_addressed();
        word_t got;
        out_ready = 1'b1;
        beat(1'b1, 1'b1, 6'd63, 1'b0);
        beat(1'b1, 1'b1, 6'd0,  1'b0);
        beat(1'b0, 1'b1, 6'd5,  1'b0);
        beat(1'b1, 1'b1, 6'd5,  1'b1);
        @(negedge clk);
        got = grab_a();
        if (got.data !== 64'h8000_0000_0000_0021 || got.mask !== 64'h8000_0000_0000_0021 ||
            got.count !== 7'd4 || got.dup !== 1'b1) begin
            bad++;
            $display("FAIL addressed got d=%h m=%h c=%0d u=%0b want d=8000000000000021 m=8000000000000021 c=4 u=1",
                     got.data, got.mask, got.count, got.dup);
        end
        total++;
        idle(2);
    endtask

    task automatic test_backpressure();
        word_t w1, w2, got;
        out_ready = 1'b0;
        rand_seq_word(8); w1 = model_word(1'b1); send_word();
        rand_seq_word(8); w2 = model_word(1'b1); send_word();
        @(negedge clk);
        got = grab_a();
        if (ia_ready !== 1'b0 || oa_valid !== 1'b1 || got !== w1) begin
            bad++;
            $display("FAIL bp_pend got rdy=%0b v=%0b d=%h want rdy=0 v=1 d=%h", ia_ready, oa_valid, got.data, w1.data);
        end
        total++;
        idle(3);
        @(negedge clk);
        got = grab_a();
        if (got !== w1 || ia_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold got d=%h rdy=%0b want d=%h rdy=0", got.data, ia_ready, w1.data);
        end
        total++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        got = grab_a();
        if (oa_valid !== 1'b1 || got !== w2 || ia_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got v=%0b d=%h c=%0d rdy=%0b want v=1 d=%h c=%0d rdy=1",
                     oa_valid, got.data, got.count, ia_ready, w2.data, w2.count);
        end
        total++;
        out_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_back_to_back();
        word_t w1, w2, got;
        out_ready = 1'b0;
        rand_seq_word(8); w1 = model_word(1'b1); send_word();
        rand_seq_word(8); w2 = model_word(1'b1);
        for (int i = 0; i < 7; i++) beat(wq[i].b, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        got = grab_a();
        if (got !== w1 || oa_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got v=%0b d=%h want v=1 d=%h", oa_valid, got.data, w1.data);
        end
        total++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        beat(wq[7].b, 1'b0, 6'd0, 1'b1);
        out_ready = 1'b0;
        @(negedge clk);
        got = grab_a();
        if (oa_valid !== 1'b1 || got !== w2 || ia_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drain got v=%0b d=%h rdy=%0b want v=1 d=%h rdy=1",
                     oa_valid, got.data, ia_ready, w2.data);
        end
        total++;
        out_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_count_sat();
        word_t exp, got;
        out_ready = 1'b1;
        wq.delete();
        for (int i = 0; i < 130; i++)
            wq.push_back('{b: 1'($urandom), m: 1'b1, s: 6'($urandom_range(0, 63))});
        exp = model_word(1'b1);
        send_word();
        @(negedge clk);
        got = grab_a();
        if (got !== exp) begin
            bad++;
            $display("FAIL count_sat got d=%h m=%h c=%0d u=%0b want d=%h m=%h c=%0d u=%0b",
                     got.data, got.mask, got.count, got.dup, exp.data, exp.mask, exp.count, exp.dup);
        end
        total++;
        idle(2);
    endtask

    task automatic test_reset_mid();
        word_t exp_l, exp_m, ga, gb;
        out_ready = 1'b0;
        rand_seq_word(8); send_word();
        for (int i = 0; i < 30; i++) beat(1'($urandom), 1'b0, 6'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        ga = grab_a();
        gb = grab_b();
        if (ga !== '0 || gb !== '0 || oa_valid !== 1'b0 || ob_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got d=%h m=%h c=%0d v=%0b want all 0", ga.data, ga.mask, ga.count, oa_valid);
        end
        total++;
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        rand_seq_word(64);
        exp_l = model_word(1'b1);
        exp_m = model_word(1'b0);
        for (int i = 0; i < 64; i++) beat(wq[i].b, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        ga = grab_a();
        gb = grab_b();
        if (ga !== exp_l || oa_valid !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_lsb got v=%0b d=%h m=%h c=%0d want v=1 d=%h m=%h c=64",
                     oa_valid, ga.data, ga.mask, ga.count, exp_l.data, exp_l.mask);
        end
        total++;
        if (gb !== exp_m) begin
            bad++;
            $display("FAIL post_reset_msb got d=%h m=%h want d=%h m=%h", gb.data, gb.mask, exp_m.data, exp_m.mask);
        end
        total++;
        idle(2);
    endtask

    task automatic test_random();
        int n, seq, waited;
        logic m;
        idle(2);
        cap_a.delete(); cap_b.delete(); exp_a.delete(); exp_b.delete();
        rand_ready = 1'b1;
        for (int w = 0; w < 40; w++) begin
            n = (w % 10 == 9) ? 64 : $urandom_range(1, 72);
            seq = 0;
            wq.delete();
            for (int i = 0; i < n; i++) begin
                m = 1'($urandom);
                if (!m && seq == 63 && i != n - 1) m = 1'b1;
                if (!m) seq++;
                wq.push_back('{b: 1'($urandom), m: m, s: 6'($urandom_range(0, 63))});
            end
            exp_a.push_back(model_word(1'b1));
            exp_b.push_back(model_word(1'b0));
            send_word();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while ((cap_a.size() < exp_a.size() || cap_b.size() < exp_b.size()) && waited < 50) begin
            idle(1);
            waited++;
        end
        idle(3);
        if (cap_a.size() != exp_a.size() || cap_b.size() != exp_b.size()) begin
            bad++;
            $display("FAIL rand_count got %0d/%0d words want %0d", cap_a.size(), cap_b.size(), exp_a.size());
        end
        total++;
        for (int i = 0; i < exp_a.size() && i < cap_a.size() && i < cap_b.size(); i++) begin
            if (cap_a[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL rand_lsb[%0d] got d=%h m=%h c=%0d u=%0b want d=%h m=%h c=%0d u=%0b", i,
                         cap_a[i].data, cap_a[i].mask, cap_a[i].count, cap_a[i].dup,
                         exp_a[i].data, exp_a[i].mask, exp_a[i].count, exp_a[i].dup);
            end
            total++;
            if (cap_b[i] !== exp_b[i]) begin
                bad++;
                $display("FAIL rand_msb[%0d] got d=%h m=%h c=%0d u=%0b want d=%h m=%h c=%0d u=%0b", i,
                         cap_b[i].data, cap_b[i].mask, cap_b[i].count, cap_b[i].dup,
                         exp_b[i].data, exp_b[i].mask, exp_b[i].count, exp_b[i].dup);
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_seq_full();
        test_short();
        test_addressed();
        test_backpressure();
        test_back_to_back();
        test_count_sat();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
